reg_file: RTL and testbench

Two-read, one-write general-purpose register file that sits directly upstream of the ALU. It supplies both ALU operands (i_a, i_b) from registers selected by the instruction's source fields, and it accepts the ALU result (or other writeback data) on its single write port. Register 0 is hardwired to zero. A same-cycle write to a register being read is forwarded to the read port, so the ALU sees the new value without a stall.

---
 rtl/reg_file.sv | 65 ++++++
 tb/tb_reg_file.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// Register file with two combinational read ports and one write port. r0 is hardwired to zero.
// A write in the current cycle is forwarded to matching read ports, except while reset is high.
module reg_cell #(
    parameter int N = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         wen,
    input  logic [N-1:0] wd,
    output logic [N-1:0] q
);
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            q <= '0;
        else if (wen)
            q <= wd;
    end
endmodule

module reg_file #(
    parameter int N = 32,
    parameter int M = 5
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [M-1:0] i_ra1,
    input  logic [M-1:0] i_ra2,
    output logic [N-1:0] o_rd1,
    output logic [N-1:0] o_rd2,
    input  logic         i_we,
    input  logic [M-1:0] i_wa,
    input  logic [N-1:0] i_wd
);
    localparam int DEPTH = 2 ** M;

    // Entry 0 has no storage. It is tied to zero so that read muxing stays uniform.
    logic [DEPTH-1:0][N-1:0] regs;

    assign regs[0] = '0;

    for (genvar i = 1; i < DEPTH; i++) begin : g_reg
        reg_cell #(.N(N)) u_cell (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .wen   (i_we && (i_wa == M'(i))),
            .wd    (i_wd),
            .q     (regs[i])
        );
    end

    function automatic logic [N-1:0] rd_sel(input logic [M-1:0] ra);
        logic [N-1:0] v;
        v = regs[ra];
        if (i_rst || ra == '0)
            v = '0;
        else if (i_we && i_wa == ra)
            v = i_wd;
        return v;
    endfunction

    always_comb begin
        o_rd1 = rd_sel(i_ra1);
        o_rd2 = rd_sel(i_ra2);
    end
endmodule

// File: tb/tb_reg_file.sv
// Directed and reference-model checks for reg_file.
module tb_reg_file;
    logic        clk;
    logic        rst;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] wd;
    logic        we;
    int          checks;
    int          errors;
    logic [31:0] ref_mem [32];

    reg_file #(.N(32), .M(5)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .i_ra1 (ra1),
        .i_ra2 (ra2),
        .o_rd1 (rd1),
        .o_rd2 (rd2),
        .i_we  (we),
        .i_wa  (wa),
        .i_wd  (wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1;
        wa = a;
        wd = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] ra);
        if (ra == 5'd0)
            return 32'h0;
        if (we && wa == ra)
            return wd;
        return ref_mem[ra];
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        we = 1'b1;
        wa = 5'd5;
        wd = 32'hCAFEF00D;
        ra1 = 5'd5;
        ra2 = 5'd31;
        #2;
        chk("reset_rd1_bypass_off", rd1, 32'h0);
        chk("reset_rd2", rd2, 32'h0);
        @(negedge clk);
        we = 1'b0;
        rst = 1'b0;

        // Clear asynchronously with no clock edge inside the reset pulse.
        wr(5, 32'hDEADBEEF);
        wr(31, 32'h12345678);
        #1;
        chk("pre_reset_r5", rd1, 32'hDEADBEEF);
        chk("pre_reset_r31", rd2, 32'h12345678);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("async_clr_r5", rd1, 32'h0);
        chk("async_clr_r31", rd2, 32'h0);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rel_r5", rd1, 32'h0);
        chk("post_rel_r31", rd2, 32'h0);

        wr(3, 32'h00000007);
        wr(4, 32'hFFFFFFF9);
        ra1 = 5'd3;
        ra2 = 5'd4;
        #1;
        chk("basic_r3", rd1, 32'h00000007);
        chk("basic_r4", rd2, 32'hFFFFFFF9);

        @(negedge clk);
        we = 1'b1;
        wa = 5'd0;
        wd = 32'hAAAAAAAA;
        ra1 = 5'd0;
        ra2 = 5'd0;
        #1;
        chk("r0_wcycle_rd1", rd1, 32'h0);
        chk("r0_wcycle_rd2", rd2, 32'h0);
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        chk("r0_after_rd1", rd1, 32'h0);
        chk("r0_after_rd2", rd2, 32'h0);

        wr(7, 32'h11);
        @(negedge clk);
        ra1 = 5'd7;
        ra2 = 5'd7;
        wa = 5'd7;
        wd = 32'h22;
        we = 1'b0;
        #1;
        chk("nobyp_rd1", rd1, 32'h11);
        chk("nobyp_rd2", rd2, 32'h11);
        we = 1'b1;
        #1;
        chk("byp_rd1", rd1, 32'h22);
        chk("byp_rd2", rd2, 32'h22);
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        chk("byp_stored_rd1", rd1, 32'h22);
        chk("byp_stored_rd2", rd2, 32'h22);

        // The write is lost when reset is high at the edge.
        wr(9, 32'h55);
        @(negedge clk);
        ra1 = 5'd9;
        we = 1'b1;
        wa = 5'd9;
        wd = 32'h99;
        #4;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_wr_during", rd1, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        we = 1'b0;
        #1;
        chk("rst_wr_release", rd1, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_wr_later", rd1, 32'h0);

        ref_mem[0] = 32'h0;
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 32'(i) * 32'h01010101);
            ref_mem[i] = 32'(i) * 32'h01010101;
        end
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            #1;
            chk("sweep_rd1", rd1, (i == 0) ? 32'h0 : 32'(i) * 32'h01010101);
            chk("sweep_rd2", rd2, (i == 31) ? 32'h0 : 32'(31 - i) * 32'h01010101);
        end

        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            ra1 = 5'($urandom_range(0, 31));
            ra2 = (c % 7 == 0) ? ra1 : 5'($urandom_range(0, 31));
            we = 1'($urandom_range(0, 1));
            wa = (c % 5 == 0) ? ra1 : 5'($urandom_range(0, 31));
            wd = $urandom;
            #1;
            chk("rand_rd1", rd1, model_rd(ra1));
            chk("rand_rd2", rd2, model_rd(ra2));
            if (we && wa != 5'd0)
                ref_mem[wa] = wd;
        end
        @(negedge clk);
        we = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
